// File: rtl/z80_mem_responder_pkg.sv
// Shared widths, FSM state encoding and error codes for the Z80 memory responder.
package z80_mem_responder_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ERR_W  = 2;
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [ERR_W-1:0] ERR_NONE     = 2'd0;
    localparam logic [ERR_W-1:0] ERR_ROM_WR   = 2'd1;
    localparam logic [ERR_W-1:0] ERR_CONFLICT = 2'd2;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT  = 2'd3;

endpackage

// File: rtl/z80_mem_responder_mem_wait_timer.sv
// Loadable wait-state down-counter and timeout up-counter, both saturating,
// with decoded flags for the responder FSM.
module z80_mem_responder_mem_wait_timer
    import z80_mem_responder_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic run_i,
    output logic wait_last_c_o,
    output logic timeout_c_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [TW-1:0]     to_q, to_d;

    // wait_last: the wait counter reaches zero on the coming edge
    assign wait_last_c_o = (wait_q <= WAIT_W'(1));
    assign timeout_c_o   = (to_q == TW'(TIMEOUT - 1));

    always_comb begin
        wait_d = wait_q;
        to_d   = to_q;
        if (load_i) begin
            wait_d = WAIT_W'(WAIT_STATES);
            to_d   = '0;
        end else if (run_i) begin
            if (wait_q != '0) begin
                wait_d = wait_q - WAIT_W'(1);
            end
            if (!timeout_c_o) begin
                to_d = to_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
            to_q   <= '0;
        end else begin
            wait_q <= wait_d;
            to_q   <= to_d;
        end
    end

endmodule

// File: rtl/z80_mem_responder.sv
// Memory-side responder for the Z80 core: bridges CPU memory cycles to a
// req/ack backing store with wait states, ROM write protection and timeout.
module z80_mem_responder
    import z80_mem_responder_pkg::*;
#(
    parameter int unsigned        WAIT_STATES  = 1,
    parameter logic [ADDR_W-1:0]  ROM_TOP      = 16'h3FFF,
    parameter int unsigned        TIMEOUT      = 64,
    parameter logic [DATA_W-1:0]  TIMEOUT_DATA = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_mreq,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic              cpu_m1,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_dout,
    output logic [DATA_W-1:0] cpu_din,
    output logic              cpu_wait,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err,
    output logic [ERR_W-1:0]  err_code
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              wait_q, wait_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [ERR_W-1:0]  code_q, code_d;

    logic start_c, conflict_c, rom_hit_c;
    logic tmr_load_c, tmr_run_c, wait_last_c, timeout_c;

    // M1 only tags cycles for statistics; it does not alter the access
    logic unused_m1;
    assign unused_m1 = cpu_m1;

    assign start_c    = cpu_mreq & (cpu_rd ^ cpu_wr);
    assign conflict_c = cpu_mreq & cpu_rd & cpu_wr;
    assign rom_hit_c  = (cpu_addr <= ROM_TOP);
    assign tmr_load_c = (state_q == ST_IDLE) & start_c;
    assign tmr_run_c  = (state_q == ST_REQ) | (state_q == ST_HOLD);

    z80_mem_responder_mem_wait_timer #(
        .WAIT_STATES (WAIT_STATES),
        .TIMEOUT     (TIMEOUT)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .load_i        (tmr_load_c),
        .run_i         (tmr_run_c),
        .wait_last_c_o (wait_last_c),
        .timeout_c_o   (timeout_c)
    );

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        wait_d  = wait_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (conflict_c) begin
                    err_d   = 1'b1;
                    code_d  = ERR_CONFLICT;
                    state_d = ST_DONE;
                end else if (start_c) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_dout;
                    we_d    = cpu_wr;
                    if (cpu_wr && rom_hit_c) begin
                        err_d  = 1'b1;
                        code_d = ERR_ROM_WR;
                        if (WAIT_STATES == 0) begin
                            state_d = ST_DONE;
                        end else begin
                            wait_d  = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        req_d   = 1'b1;
                        wait_d  = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // An abandoned cycle still finishes on the bus; its result is dropped
                if (mem_ack) begin
                    req_d = 1'b0;
                    if (cpu_mreq) begin
                        if (!we_q) begin
                            din_d = mem_rdata;
                        end
                        state_d = ST_HOLD;
                    end else begin
                        wait_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else if (timeout_c) begin
                    req_d  = 1'b0;
                    err_d  = 1'b1;
                    code_d = ERR_TIMEOUT;
                    if (cpu_mreq) begin
                        if (!we_q) begin
                            din_d = TIMEOUT_DATA;
                        end
                        state_d = ST_HOLD;
                    end else begin
                        wait_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (!cpu_mreq) begin
                    wait_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (wait_last_c) begin
                    wait_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!cpu_mreq) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            din_q   <= '0;
            wait_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            wait_q  <= wait_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign cpu_din   = din_q;
    assign cpu_wait  = wait_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_z80_mem_responder.sv
// Directed bench for z80_mem_responder: vector table of complete CPU cycles
// plus hand-written reset and abandoned-cycle sequences.
module tb_z80_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mreq, cpu_rd, cpu_wr, cpu_m1;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_wait;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    z80_mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_mreq  (cpu_mreq),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_m1    (cpu_m1),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_din   (cpu_din),
        .cpu_wait  (cpu_wait),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ack_dly: mem_ack is driven during the n-th cycle mem_req is high (0 = never)
    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          ack_dly;
        logic [7:0]  rdata;
        int          exp_req;
        int          exp_wait;
        logic [7:0]  exp_din;
        int          exp_errs;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 16'h4000, 8'h00, 1,  8'hA5, 1,  2,  8'hA5, 0, 2'd0};
        vecs[1] = '{1'b0, 1'b1, 16'h8000, 8'h3C, 5,  8'h00, 5,  6,  8'hA5, 0, 2'd0};
        vecs[2] = '{1'b0, 1'b1, 16'h0100, 8'h42, 1,  8'h00, 0,  1,  8'hA5, 1, 2'd1};
        vecs[3] = '{1'b1, 1'b0, 16'h1234, 8'h00, 3,  8'h5A, 3,  4,  8'h5A, 0, 2'd1};
        vecs[4] = '{1'b1, 1'b0, 16'h9000, 8'h00, 0,  8'h00, 64, 65, 8'hFF, 1, 2'd3};
        vecs[5] = '{1'b1, 1'b1, 16'h5000, 8'h12, 1,  8'h00, 0,  0,  8'hFF, 1, 2'd2};
        vecs[6] = '{1'b0, 1'b1, 16'h3FFF, 8'h11, 1,  8'h00, 0,  1,  8'hFF, 1, 2'd1};
        vecs[7] = '{1'b0, 1'b1, 16'h4000, 8'h77, 2,  8'h00, 2,  3,  8'hFF, 0, 2'd1};
        vecs[8] = '{1'b1, 1'b0, 16'hC000, 8'h00, 64, 8'h3C, 64, 65, 8'h3C, 0, 2'd1};
        vecs[9] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 1,  8'h5C, 1,  2,  8'h5C, 0, 2'd1};

        reset     = 1'b1;
        cpu_mreq  = 1'b0;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_m1    = 1'b0;
        cpu_addr  = '0;
        cpu_dout  = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        #12;
        check("rst_din",   32'(cpu_din),   32'h00);
        check("rst_wait",  32'(cpu_wait),  32'h0);
        check("rst_req",   32'(mem_req),   32'h0);
        check("rst_we",    32'(mem_we),    32'h0);
        check("rst_addr",  32'(mem_addr),  32'h0);
        check("rst_wdata", 32'(mem_wdata), 32'h0);
        check("rst_err",   32'(err),       32'h0);
        check("rst_code",  32'(err_code),  32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            int          reqc, waitc, errc;
            logic        seen_we, done;
            logic [15:0] seen_addr;
            logic [7:0]  seen_wd;
            reqc = 0; waitc = 0; errc = 0; done = 1'b0;
            seen_we = 1'b0; seen_addr = '0; seen_wd = '0;
            cpu_mreq = 1'b1;
            cpu_rd   = vecs[i].rd;
            cpu_wr   = vecs[i].wr;
            cpu_m1   = vecs[i].rd;
            cpu_addr = vecs[i].addr;
            cpu_dout = vecs[i].wdata;
            for (int cyc = 0; cyc < 300 && !done; cyc++) begin
                tick();
                mem_ack = 1'b0;
                if (mem_req) begin
                    reqc++;
                    if (reqc == 1) begin
                        seen_we   = mem_we;
                        seen_addr = mem_addr;
                        seen_wd   = mem_wdata;
                    end
                    if (reqc == vecs[i].ack_dly) begin
                        mem_ack   = 1'b1;
                        mem_rdata = vecs[i].rdata;
                    end
                end
                if (cpu_wait) waitc++;
                if (err) errc++;
                if (!cpu_wait && !mem_req) done = 1'b1;
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL v%0d_bound actual=not_done required=done", i);
            end
            check($sformatf("v%0d_req_cycles", i),  32'(reqc),  32'(vecs[i].exp_req));
            check($sformatf("v%0d_wait_cycles", i), 32'(waitc), 32'(vecs[i].exp_wait));
            check($sformatf("v%0d_din", i),         32'(cpu_din), 32'(vecs[i].exp_din));
            check($sformatf("v%0d_err_pulses", i),  32'(errc),  32'(vecs[i].exp_errs));
            check($sformatf("v%0d_err_code", i),    32'(err_code), 32'(vecs[i].exp_code));
            if (vecs[i].exp_req > 0) begin
                check($sformatf("v%0d_mem_we", i),   32'(seen_we),   32'(vecs[i].wr));
                check($sformatf("v%0d_mem_addr", i), 32'(seen_addr), 32'(vecs[i].addr));
                if (vecs[i].wr) begin
                    check($sformatf("v%0d_mem_wdata", i), 32'(seen_wd), 32'(vecs[i].wdata));
                end
            end
            cpu_mreq = 1'b0;
            cpu_rd   = 1'b0;
            cpu_wr   = 1'b0;
            cpu_m1   = 1'b0;
            mem_ack  = 1'b0;
            tick();
            tick();
        end

        // Strobe dropped mid-REQ: bus access completes, data is discarded
        cpu_mreq = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'hB000;
        tick();
        check("drop_req_start", 32'(mem_req), 32'h1);
        cpu_mreq = 1'b0; cpu_rd = 1'b0; cpu_addr = 16'h2222;
        tick();
        check("drop_req_held", 32'(mem_req), 32'h1);
        check("drop_addr_latched", 32'(mem_addr), 32'hB000);
        tick();
        mem_ack = 1'b1; mem_rdata = 8'h99;
        tick();
        mem_ack = 1'b0;
        check("drop_req_low",  32'(mem_req),  32'h0);
        check("drop_wait_low", 32'(cpu_wait), 32'h0);
        check("drop_din_kept", 32'(cpu_din),  32'h5C);
        check("drop_no_err",   32'(err),      32'h0);
        tick();
        check("drop_idle_req", 32'(mem_req), 32'h0);

        // Reset in the middle of an access, then a stale ack
        cpu_mreq = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'hA000;
        tick();
        check("rstmid_req_before", 32'(mem_req), 32'h1);
        #2;
        reset = 1'b1;
        cpu_mreq = 1'b0; cpu_rd = 1'b0;
        #1;
        check("rstmid_req_async",  32'(mem_req),  32'h0);
        check("rstmid_wait_async", 32'(cpu_wait), 32'h0);
        check("rstmid_din_async",  32'(cpu_din),  32'h00);
        check("rstmid_code_async", 32'(err_code), 32'h0);
        check("rstmid_addr_async", 32'(mem_addr), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        tick();
        mem_ack = 1'b0;
        tick();
        check("stale_ack_req",  32'(mem_req),  32'h0);
        check("stale_ack_din",  32'(cpu_din),  32'h00);
        check("stale_ack_wait", 32'(cpu_wait), 32'h0);
        check("stale_ack_err",  32'(err),      32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/z80_mem_responder.md
Name: z80_mem_responder

Overview:
- Memory-side responder for the CPU core's memory bus: accepts CPU read/write cycles (address, write data, strobes), returns read data and holds the CPU with a wait signal until the access completes.
- Bridges to a backing store over a req/ack handshake.
- Adds programmable wait states, a write-protected ROM window and an access timeout.
- Sits between the core's memory interface and on-chip RAM/ROM or an external bus adapter.

Parameters:
- WAIT_STATES, 1: minimum cycles cpu_wait stays high after a strobe is accepted (0..15).
- ROM_TOP, 16'h3FFF: addresses 0..ROM_TOP are read-only.
- TIMEOUT, 64: backing-store cycles allowed before abort (≥ WAIT_STATES+2).
- TIMEOUT_DATA, 8'hFF: read data returned on timeout.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous reset, active-high
- cpu_mreq  in  1  memory request, level, held for the whole cycle
- cpu_rd  in  1  read strobe, qualified by cpu_mreq
- cpu_wr  in  1  write strobe, qualified by cpu_mreq
- cpu_m1  in  1  opcode-fetch cycle marker (statistics/err tagging only)
- cpu_addr  in  16  CPU address
- cpu_dout  in  8  CPU write data
- cpu_din  out  8  read data to CPU
- cpu_wait  out  1  high = CPU must hold the cycle
- mem_req  out  1  backing-store request
- mem_we  out  1  backing-store write enable
- mem_addr  out  16  backing-store address
- mem_wdata  out  8  backing-store write data
- mem_rdata  in  8  backing-store read data, valid with mem_ack
- mem_ack  in  1  single-cycle completion pulse
- err  out  1  one-cycle pulse: ROM write, rd+wr conflict, or timeout
- err_code  out  2  0 none, 1 rom_wr, 2 conflict, 3 timeout; held until the next err

Behaviour:
- Reset (asynchronous, immediate): state IDLE; cpu_din=8'h00, cpu_wait=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0, err_code=0, counters=0. Reset mid-access drops mem_req at once. A late mem_ack after reset is ignored.
- Start condition (IDLE): cpu_mreq & (cpu_rd ^ cpu_wr) on a rising edge.
  - Latch cpu_addr/cpu_dout/direction into mem_addr/mem_wdata/mem_we.
  - cpu_wait=1 from the next cycle.
  - wait counter = WAIT_STATES, timeout counter = 0.
  - Go to REQ.
- cpu_mreq & cpu_rd & cpu_wr in IDLE: no access; err pulse, code 2; go to DONE so the cycle can end.
- Write with address ≤ ROM_TOP: no mem_req; err pulse, code 1; cpu_wait=1 for WAIT_STATES cycles; then DONE.
- REQ:
  - mem_req=1, held until mem_ack.
  - On mem_ack: mem_req=0 in the same clocked update; on a read, capture mem_rdata into cpu_din; go to HOLD.
  - Timeout counter increments each cycle. When it reaches TIMEOUT-1 without ack: drop mem_req, cpu_din=TIMEOUT_DATA on reads, err pulse, code 3, go to HOLD.
- HOLD: the wait counter decrements every cycle from the start, including during REQ. Exit to DONE once the counter is 0 and the ack/timeout has happened. cpu_wait falls on DONE entry.
- Minimum read latency (strobe edge to cpu_wait low) is max(WAIT_STATES, ack latency+1) cycles. With ack in the first REQ cycle and WAIT_STATES=1 this is 2 cycles.
- DONE: cpu_wait=0; cpu_din stable. Return to IDLE when cpu_mreq=0. A new access needs mreq to deassert first (no back-to-back without a gap).
- cpu_din holds its last value except on read completion.
- Strobe dropped mid-REQ: the backing-store access still completes (no abort); result discarded; IDLE after ack/timeout.
- Address/data changes during REQ are ignored (latched at start).
- Counters saturate and do not wrap.

Decomposition:
- Shared package/header (alongside buswidth.vh): state encoding constants (IDLE, REQ, HOLD, DONE) and err_code constants (ERR_NONE, ERR_ROM_WR, ERR_CONFLICT, ERR_TIMEOUT).
- One natural sub-module: mem_wait_timer, a loadable down/up counter pair with zero/timeout flags. Used for the wait-state and timeout counting.

Test Plan:
- Read 0x4000 with WAIT_STATES=1, ack one cycle after mem_req, mem_rdata=0xA5 → mem_req high 1 cycle, cpu_din=0xA5, cpu_wait high exactly 2 cycles, err=0.
- Write 0x8000=0x3C, ack delayed 5 cycles → mem_we=1, mem_addr=0x8000, mem_wdata=0x3C; cpu_wait low the cycle after ack.
- Write to 0x0100 (ROM) → no mem_req; err pulse with code 1; cpu_wait high WAIT_STATES cycles; memory untouched.
- Read with ack never asserted, TIMEOUT=64 → mem_req drops after 64 cycles; cpu_din=0xFF; err code 3.
- cpu_rd and cpu_wr both high with mreq → no mem_req; err code 2; cpu_wait stays 0.
- reset asserted while mem_req=1, then ack arrives after reset release → outputs return to reset values asynchronously; stale ack ignored; cpu_din=0x00.
